// File: rtl/llr_extr_pkg.sv
// Shared constants, trellis tables and output word reduction for llr_extr_calc_pipe.
// Build option LLR_EXTR_SAT_EN selects symmetric saturation instead of two's-complement wrap.
package llr_extr_pkg;

  localparam int PIPE_LAT = 9;
  localparam int N_STATES = 8;
  localparam int N_EXPR   = 8;
  localparam int N_TERMS  = 2 * N_EXPR;

  // Term t = 2*expr + pair. Expressions 0..3 subtract the branch metric, 4..7 add it.
  localparam int ALPHA_IDX [N_TERMS] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3, 4, 5, 6, 7};
  localparam int BETA_IDX  [N_TERMS] = '{4, 0, 1, 5, 6, 2, 3, 7, 0, 4, 5, 1, 2, 6, 7, 3};
  localparam bit BR_SEL    [N_TERMS] = '{0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
  localparam bit BR_SIGN   [N_TERMS] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};

  // Reduce a wide signed value to dw bits; the result is returned sign-extended.
  function automatic logic signed [63:0] reduce_word(input logic signed [63:0] x,
                                                      input int dw);
`ifdef LLR_EXTR_SAT_EN
    logic signed [63:0] lim;
    lim = (64'sd1 <<< (dw - 1)) - 64'sd1;
    if (x > lim)       return lim;
    else if (x < -lim) return -lim;
    else               return x;
`else
    logic signed [63:0] sh;
    sh = x <<< (64 - dw);
    return sh >>> (64 - dw);
`endif
  endfunction

endpackage

// File: rtl/llr_extr_calc_pipe_max_tree.sv
// Two-level registered signed max over four operands (pipeline stages 4 and 5).
// Two instances together reduce the eight trellis expressions to max0123 / max4567.
module llr_max_tree
  import llr_extr_pkg::*;
#(
  parameter int W = 19
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                en,
  input  logic [4*W-1:0]      din,
  output logic signed [W-1:0] dout
);

  logic signed [W-1:0] lvl1 [2];

  // Ties keep the first operand.
  function automatic logic signed [W-1:0] smax(input logic signed [W-1:0] a,
                                               input logic signed [W-1:0] b);
    return (a >= b) ? a : b;
  endfunction

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      lvl1[0] <= '0;
      lvl1[1] <= '0;
      dout    <= '0;
    end else if (en) begin
      lvl1[0] <= smax(din[0*W +: W], din[1*W +: W]);
      lvl1[1] <= smax(din[2*W +: W], din[3*W +: W]);
      dout    <= smax(lvl1[0], lvl1[1]);
    end
  end

endmodule

// File: rtl/llr_extr_calc_pipe.sv
// Nine-stage max-log-MAP LLR / scaled extrinsic calculator with global-stall backpressure.
// Build option LLR_EXTR_SAT_EN: saturate llr/extr symmetrically instead of wrapping.
module llr_extr_calc_pipe
  import llr_extr_pkg::*;
#(
  parameter int DWIDTH     = 16,
  parameter int EXTR_NUM   = 3,
  parameter int EXTR_SHIFT = 2,
  parameter int GUARD      = 3
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [8*DWIDTH-1:0]     s_alpha,
  input  logic [8*DWIDTH-1:0]     s_beta,
  input  logic [DWIDTH-1:0]       s_branch1,
  input  logic [DWIDTH-1:0]       s_branch2,
  input  logic [DWIDTH-1:0]       s_sys,
  input  logic                    s_sof,
  input  logic                    s_eof,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [DWIDTH-1:0]       m_llr,
  output logic [DWIDTH-1:0]       m_extr,
  output logic                    m_sof,
  output logic                    m_eof,
  output logic                    m_valid,
  input  logic                    m_ready
);

  localparam int IW = DWIDTH + GUARD;
  localparam int PW = DWIDTH + 5;
  localparam logic signed [4:0] NUM_S = 5'(EXTR_NUM);

  // Handshake: a beat moves on s_* when s_valid & s_ready and on m_* when m_valid & m_ready;
  // the whole pipe advances together, so s_ready is simply the output-side advance.
  logic adv;
  assign adv     = !m_valid || m_ready;
  assign s_ready = adv;

  logic [PIPE_LAT-1:0] vld_sr, sof_sr, eof_sr;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      vld_sr <= '0;
      sof_sr <= '0;
      eof_sr <= '0;
    end else if (adv) begin
      vld_sr <= {vld_sr[PIPE_LAT-2:0], s_valid};
      sof_sr <= {sof_sr[PIPE_LAT-2:0], s_valid & s_sof};
      eof_sr <= {eof_sr[PIPE_LAT-2:0], s_valid & s_eof};
    end
  end

  assign m_valid = vld_sr[PIPE_LAT-1];
  assign m_sof   = sof_sr[PIPE_LAT-1];
  assign m_eof   = eof_sr[PIPE_LAT-1];

  logic signed [IW-1:0] alpha_x [N_STATES];
  logic signed [IW-1:0] beta_x  [N_STATES];
  logic signed [IW-1:0] br_x    [2];

  always_comb begin
    for (int i = 0; i < N_STATES; i++) begin
      alpha_x[i] = IW'($signed(s_alpha[i*DWIDTH +: DWIDTH]));
      beta_x[i]  = IW'($signed(s_beta[i*DWIDTH +: DWIDTH]));
    end
    br_x[0] = IW'($signed(s_branch1));
    br_x[1] = IW'($signed(s_branch2));
  end

  function automatic logic signed [IW-1:0] smax(input logic signed [IW-1:0] a,
                                                input logic signed [IW-1:0] b);
    return (a >= b) ? a : b;
  endfunction

  logic signed [IW-1:0]     s1_part [N_TERMS];
  logic signed [IW-1:0]     s1_beta [N_STATES];
  logic signed [IW-1:0]     s2_term [N_TERMS];
  logic [4*IW-1:0]          s3_lo, s3_hi;
  logic signed [DWIDTH-1:0] sys_d [6];

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int t = 0; t < N_TERMS; t++) begin
        s1_part[t] <= '0;
        s2_term[t] <= '0;
      end
      for (int i = 0; i < N_STATES; i++) s1_beta[i] <= '0;
      for (int i = 0; i < 6; i++) sys_d[i] <= '0;
      s3_lo <= '0;
      s3_hi <= '0;
    end else if (adv) begin
      for (int t = 0; t < N_TERMS; t++) begin
        s1_part[t] <= BR_SIGN[t] ? alpha_x[ALPHA_IDX[t]] - br_x[BR_SEL[t]]
                                 : alpha_x[ALPHA_IDX[t]] + br_x[BR_SEL[t]];
        s2_term[t] <= s1_part[t] + s1_beta[BETA_IDX[t]];
      end
      for (int i = 0; i < N_STATES; i++) s1_beta[i] <= beta_x[i];
      sys_d[0] <= $signed(s_sys);
      for (int i = 1; i < 6; i++) sys_d[i] <= sys_d[i-1];
      for (int e = 0; e < 4; e++) begin
        s3_lo[e*IW +: IW] <= smax(s2_term[2*e], s2_term[2*e+1]);
        s3_hi[e*IW +: IW] <= smax(s2_term[2*e+8], s2_term[2*e+9]);
      end
    end
  end

  logic signed [IW-1:0] max0123, max4567;

  llr_max_tree #(.W(IW)) u_max_lo (
    .aclk(aclk), .aresetn(aresetn), .en(adv), .din(s3_lo), .dout(max0123)
  );

  llr_max_tree #(.W(IW)) u_max_hi (
    .aclk(aclk), .aresetn(aresetn), .en(adv), .din(s3_hi), .dout(max4567)
  );

  logic signed [IW:0]       llr_wide;
  logic signed [PW-1:0]     p_shift;
  logic signed [DWIDTH-1:0] s6_llr, s7_llr, s8_llr;
  logic signed [DWIDTH:0]   s7_d;
  logic signed [PW-1:0]     s8_p;

  assign llr_wide = (IW+1)'(max0123) - (IW+1)'(max4567);
  // Arithmetic shift of a signed product rounds toward minus infinity.
  assign p_shift  = s8_p >>> EXTR_SHIFT;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      s6_llr <= '0;
      s7_llr <= '0;
      s7_d   <= '0;
      s8_llr <= '0;
      s8_p   <= '0;
      m_llr  <= '0;
      m_extr <= '0;
    end else if (adv) begin
      s6_llr <= DWIDTH'(reduce_word(64'(llr_wide), DWIDTH));
      s7_d   <= (DWIDTH+1)'(s6_llr) - (DWIDTH+1)'(sys_d[5]);
      s7_llr <= s6_llr;
      s8_p   <= PW'(s7_d) * PW'(NUM_S);
      s8_llr <= s7_llr;
      m_extr <= DWIDTH'(reduce_word(64'(p_shift), DWIDTH));
      m_llr  <= s8_llr;
    end
  end

endmodule

// File: tb/tb_llr_extr_calc_pipe.sv
// Scoreboard bench for llr_extr_calc_pipe: three instances (default, 1/1 and 11/16 scaling)
// share one stimulus stream; a negedge monitor pops and compares expected beats.
module tb_llr_extr_calc_pipe;

  localparam int DW  = 16;
  localparam int LAT = 9;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic [8*DW-1:0] s_alpha, s_beta;
  logic [DW-1:0]   s_branch1, s_branch2, s_sys;
  logic            s_sof, s_eof, s_valid, m_ready;
  logic            s_ready [3];
  logic [DW-1:0]   m_llr [3], m_extr [3];
  logic            m_sof [3], m_eof [3], m_valid [3];

  always #5 aclk = ~aclk;

  llr_extr_calc_pipe dut0 (
    .aclk(aclk), .aresetn(aresetn), .s_alpha(s_alpha), .s_beta(s_beta),
    .s_branch1(s_branch1), .s_branch2(s_branch2), .s_sys(s_sys), .s_sof(s_sof),
    .s_eof(s_eof), .s_valid(s_valid), .s_ready(s_ready[0]), .m_llr(m_llr[0]),
    .m_extr(m_extr[0]), .m_sof(m_sof[0]), .m_eof(m_eof[0]), .m_valid(m_valid[0]),
    .m_ready(m_ready)
  );

  llr_extr_calc_pipe #(.EXTR_NUM(1), .EXTR_SHIFT(0)) dut1 (
    .aclk(aclk), .aresetn(aresetn), .s_alpha(s_alpha), .s_beta(s_beta),
    .s_branch1(s_branch1), .s_branch2(s_branch2), .s_sys(s_sys), .s_sof(s_sof),
    .s_eof(s_eof), .s_valid(s_valid), .s_ready(s_ready[1]), .m_llr(m_llr[1]),
    .m_extr(m_extr[1]), .m_sof(m_sof[1]), .m_eof(m_eof[1]), .m_valid(m_valid[1]),
    .m_ready(m_ready)
  );

  llr_extr_calc_pipe #(.EXTR_NUM(11), .EXTR_SHIFT(4)) dut2 (
    .aclk(aclk), .aresetn(aresetn), .s_alpha(s_alpha), .s_beta(s_beta),
    .s_branch1(s_branch1), .s_branch2(s_branch2), .s_sys(s_sys), .s_sof(s_sof),
    .s_eof(s_eof), .s_valid(s_valid), .s_ready(s_ready[2]), .m_llr(m_llr[2]),
    .m_extr(m_extr[2]), .m_sof(m_sof[2]), .m_eof(m_eof[2]), .m_valid(m_valid[2]),
    .m_ready(m_ready)
  );

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  bit          lat_chk = 1'b0;
  logic [65:0] cur_exp;
  logic [65:0] mon_e;
  int          mon_l;
  // Entry: {sof, eof, llr, extr dut0, extr dut1, extr dut2}
  logic [65:0] exp_q [$];
  int          lat_q [$];

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Floor-divided scaled extrinsic, then reduced like the output stage.
  function automatic int ref_extr(input int llr, input int sys, input int num, input int sh);
    int p, d, q;
    p = num * (llr - sys);
    d = 1 << sh;
    if (p >= 0) q = p / d;
    else        q = -((-p + d - 1) / d);
`ifdef LLR_EXTR_SAT_EN
    if (q > 32767)  q = 32767;
    if (q < -32767) q = -32767;
    return q;
`else
    begin
      logic [15:0] w;
      w = q[15:0];
      return int'($signed(w));
    end
`endif
  endfunction

  task automatic set_vec(input int idx, input bit sof, input bit eof);
    int b1, b2, sys, llr, ex;
    s_alpha = '0;
    s_beta  = '0;
    b1 = 0; b2 = 0; sys = 0; llr = 0; ex = 0;
    case (idx)
      0: begin b1 = 10; llr = -10; ex = -8; end
      1: begin b1 = 10; sys = -20; llr = -10; ex = 7; end
      2: begin
        s_beta[3*DW +: DW] = 16'd30000;
        s_beta[7*DW +: DW] = 16'd30000;
        b1 = -20000;
`ifdef LLR_EXTR_SAT_EN
        llr = 32767; ex = 24575;
`else
        llr = -25536; ex = -19152;
`endif
      end
      3: begin b1 = -5; sys = 2; llr = 5; ex = 2; end
      4: begin b1 = 10; sys = -9; llr = -10; ex = -1; end
      5: begin b2 = 7; llr = -7; ex = -6; end
      6: begin s_beta[4*DW +: DW] = 16'd100; b1 = 30; llr = -60; ex = -45; end
      default: begin
        for (int i = 0; i < 8; i++) begin
          s_alpha[i*DW +: DW] = -16'sd1000;
          s_beta[i*DW +: DW]  = -16'sd1000;
        end
        sys = 100; llr = 0; ex = -75;
      end
    endcase
    s_branch1 = 16'(b1);
    s_branch2 = 16'(b2);
    s_sys     = 16'(sys);
    s_sof     = sof;
    s_eof     = eof;
    cur_exp   = {sof, eof, 16'(llr), 16'(ex), 16'(ref_extr(llr, sys, 1, 0)),
                 16'(ref_extr(llr, sys, 11, 4))};
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send(input int idx, input bit sof, input bit eof);
    int n;
    set_vec(idx, sof, eof);
    s_valid = 1'b1;
    n = 0;
    @(negedge aclk);
    while (!s_ready[0] && n < 100) begin
      n++;
      @(negedge aclk);
    end
    if (n >= 100) chk("accept_timeout", 66'(n), 66'(0));
    @(posedge aclk);
    #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      n++;
      @(negedge aclk);
    end
    chk("drain", 66'(exp_q.size()), 66'(0));
    @(posedge aclk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string nm);
    for (int d = 0; d < 3; d++)
      chk($sformatf("%s_dut%0d", nm, d),
          66'({m_valid[d], m_sof[d], m_eof[d], m_llr[d], m_extr[d]}), 66'(0));
  endtask

  always @(negedge aclk) begin
    if (!aresetn) begin
      exp_q.delete();
      lat_q.delete();
    end else begin
      if (s_valid && s_ready[0]) begin
        exp_q.push_back(cur_exp);
        lat_q.push_back(cyc + LAT);
      end
      chk("s_ready_rule", 66'(s_ready[0]), 66'(!m_valid[0] || m_ready));
      if (m_valid[0] && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got llr=%0h, expected no beat", m_llr[0]);
        end else begin
          mon_e = exp_q.pop_front();
          mon_l = lat_q.pop_front();
          for (int d = 0; d < 3; d++)
            chk($sformatf("out_dut%0d", d),
                66'({m_valid[d], m_sof[d], m_eof[d], m_llr[d], m_extr[d]}),
                66'({1'b1, mon_e[65], mon_e[64], mon_e[63:48], mon_e[47-16*d -: 16]}));
          if (lat_chk) chk("latency", 66'(cyc), 66'(mon_l));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    set_vec(0, 1'b0, 1'b0);
    s_valid = 1'b0;
    m_ready = 1'b1;
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk_reset_outputs("reset_state");
    @(posedge aclk);
    #1 aresetn = 1'b1;
    @(negedge aclk);
    chk("s_ready_after_reset", 66'(s_ready[0]), 66'(1));
    @(posedge aclk);
    #1;

    // Directed vectors back to back, unstalled latency checked.
    lat_chk = 1'b1;
    for (int i = 0; i < 8; i++) send(i, i == 0, i == 7);
    s_valid = 1'b0;
    wait_drain();
    send(5, 1'b1, 1'b1);
    s_valid = 1'b0;
    wait_drain();
    lat_chk = 1'b0;

    // Twelve beats with downstream stalled on cycles 10-14.
    fork
      begin
        for (int i = 0; i < 12; i++)
          send(i % 8, (i == 0) || (i == 6) || (i == 7), (i == 5) || (i == 6) || (i == 11));
        s_valid = 1'b0;
      end
      begin
        repeat (10) @(posedge aclk);
        #1 m_ready = 1'b0;
        repeat (5) @(posedge aclk);
        #1 m_ready = 1'b1;
      end
    join
    wait_drain();

    // Reset while the fifth of eight beats is presented.
    for (int i = 0; i < 4; i++) send(i + 1, i == 0, 1'b0);
    set_vec(5, 1'b0, 1'b0);
    s_valid = 1'b1;
    aresetn = 1'b0;
    @(posedge aclk);
    #1 s_valid = 1'b0;
    @(negedge aclk);
    chk_reset_outputs("mid_reset");
    @(posedge aclk);
    #1 aresetn = 1'b1;
    repeat (20) @(negedge aclk);
    chk("s_ready_post_reset", 66'(s_ready[0]), 66'(1));
    @(posedge aclk);
    #1;
    send(6, 1'b1, 1'b1);
    s_valid = 1'b0;
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
